// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multicycle MIPS control unit
package mc_pkg;

  // Controller states, one per cycle of the multicycle sequence
  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    IEXEC  = 4'd9,
    IWB    = 4'd10,
    JUMP   = 4'd11
  } state_t;

  // How the ALU operation is chosen in the current state
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_FUNCT = 2'd2,
    CLS_IMM   = 2'd3
  } alu_class_t;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_J    = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type functs the datapath can execute; anything else is dropped in DECODE
  function automatic logic funct_supported(input logic [5:0] f);
    logic ok;
    case (f)
      FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// rtl/mc_aludec.sv - ALU operation and immediate-extension decode
module mc_aludec
  import mc_pkg::*;
(
  input  logic [5:0]  op,
  input  logic [5:0]  funct,
  input  alu_class_t  alu_class,
  output logic [2:0]  alucontrol,
  output logic        immext
);

  // Pick the ALU op from the state class, falling back to add
  always_comb begin
    alucontrol = ALU_ADD;
    immext     = 1'b0;
    case (alu_class)
      CLS_ADD: alucontrol = ALU_ADD;
      CLS_SUB: alucontrol = ALU_SUB;
      CLS_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        // Logical immediates zero-extend; arithmetic ones sign-extend
        case (op)
          OP_ADDI: begin alucontrol = ALU_ADD; immext = 1'b0; end
          OP_SLTI: begin alucontrol = ALU_SLT; immext = 1'b0; end
          OP_ANDI: begin alucontrol = ALU_AND; immext = 1'b1; end
          OP_ORI:  begin alucontrol = ALU_OR;  immext = 1'b1; end
          default: begin alucontrol = ALU_ADD; immext = 1'b0; end
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multicycle MIPS control unit with memory-ready waits
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memtoreg,
  output logic [1:0] pcsrc,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic       regdst,
  output logic       regwrite,
  output logic [2:0] alucontrol,
  output logic       pcen,
  output logic       immext,
  output logic       memwrite,
  output logic       irwrite,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  alu_class_t alu_class;

  assign state = state_q;

  // State register; reset aborts whatever instruction is in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Next-state selection; memory states hold until memready
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:  if (memready) state_d = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                       state_d = MEMADR;
          OP_R:                               state_d = funct_supported(funct) ? REXEC : FETCH;
          OP_BEQ, OP_BNE:                     state_d = BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI:  state_d = IEXEC;
          OP_J:                               state_d = JUMP;
          default:                            state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  if (memready) state_d = MEMWB;
      MEMWB:  state_d = FETCH;
      MEMWR:  if (memready) state_d = FETCH;
      REXEC:  state_d = RWB;
      RWB:    state_d = FETCH;
      BRANCH: state_d = FETCH;
      IEXEC:  state_d = IWB;
      IWB:    state_d = FETCH;
      JUMP:   state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Datapath controls per state; write strobes are suppressed during reset
  always_comb begin
    memtoreg  = 1'b0;
    pcsrc     = 2'b00;
    alusrca   = 1'b0;
    alusrcb   = 2'b00;
    regdst    = 1'b0;
    regwrite  = 1'b0;
    pcen      = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    alu_class = CLS_ADD;
    case (state_q)
      FETCH: begin
        // IR reloads every wait cycle; PC advances only once the fetch completes
        alusrcb = 2'b01;
        irwrite = 1'b1;
        pcen    = memready;
      end
      DECODE: begin
        alusrcb = 2'b11;
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      MEMWR: begin
        memwrite = 1'b1;
      end
      REXEC: begin
        alusrca   = 1'b1;
        alu_class = CLS_FUNCT;
      end
      RWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      BRANCH: begin
        alusrca   = 1'b1;
        pcsrc     = 2'b01;
        alu_class = CLS_SUB;
        pcen      = (op == OP_BNE) ? ~zero : zero;
      end
      IEXEC: begin
        alusrca   = 1'b1;
        alusrcb   = 2'b10;
        alu_class = CLS_IMM;
      end
      IWB: begin
        regwrite = 1'b1;
      end
      JUMP: begin
        pcsrc = 2'b10;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      regwrite = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
    end
  end

  mc_aludec u_aludec (
    .op         (op),
    .funct      (funct),
    .alu_class  (alu_class),
    .alucontrol (alucontrol),
    .immext     (immext)
  );

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - directed bench for the multicycle control unit
module tb_mc_controller;

  // Observed output bundle: st, memtoreg, pcsrc, alusrca, alusrcb, regdst,
  // regwrite, alucontrol, pcen, immext, memwrite, irwrite
  typedef struct packed {
    logic [3:0] st;
    logic       m2r;
    logic [1:0] pcs;
    logic       asa;
    logic [1:0] asb;
    logic       rd;
    logic       rw;
    logic [2:0] alu;
    logic       pe;
    logic       ie;
    logic       mw;
    logic       ir;
  } ov_t;

  localparam ov_t V_F_RDY  = '{4'd0,  1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam ov_t V_F_WAIT = '{4'd0,  1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam ov_t V_F_RST  = '{4'd0,  1'b0, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_DEC    = '{4'd1,  1'b0, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_MEMADR = '{4'd2,  1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_MEMRD  = '{4'd3,  1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_MEMWB  = '{4'd4,  1'b1, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_MEMWR  = '{4'd5,  1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ov_t V_WR_RST = '{4'd5,  1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_REXEC  = '{4'd6,  1'b0, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_RWB    = '{4'd7,  1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_BR_TK  = '{4'd8,  1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_BR_NT  = '{4'd8,  1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_IEXEC  = '{4'd9,  1'b0, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_IWB    = '{4'd10, 1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ov_t V_JUMP   = '{4'd11, 1'b0, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       memtoreg;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regdst;
  logic       regwrite;
  logic [2:0] alucontrol;
  logic       pcen;
  logic       immext;
  logic       memwrite;
  logic       irwrite;
  logic [3:0] state;
  ov_t        obs;

  int n_cmp = 0;
  int n_bad = 0;

  assign obs = '{state, memtoreg, pcsrc, alusrca, alusrcb, regdst, regwrite,
                 alucontrol, pcen, immext, memwrite, irwrite};

  always #5 clk = ~clk;

  mc_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memready   (memready),
    .memtoreg   (memtoreg),
    .pcsrc      (pcsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .regdst     (regdst),
    .regwrite   (regwrite),
    .alucontrol (alucontrol),
    .pcen       (pcen),
    .immext     (immext),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .state      (state)
  );

  task automatic test_reset();
    reset = 1'b1; memready = 1'b0; op = 6'b000000; funct = 6'b000000; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs !== V_F_RST) begin n_bad++; $display("FAIL reset_hold got=%h exp=%h", obs, V_F_RST); end
    memready = 1'b1;
    #1;
    n_cmp++;
    if (obs !== V_F_RST) begin n_bad++; $display("FAIL reset_hold_rdy got=%h exp=%h", obs, V_F_RST); end
    reset = 1'b0;
  endtask

  task automatic test_lw();
    ov_t seq[$];
    bit  rdy[$];
    op = 6'b100011;
    seq = '{V_F_RDY, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB,
            V_F_RDY, V_DEC, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMWB};
    rdy = '{1, 1, 1, 1, 1,
            1, 1, 1, 0, 1, 1};
    for (int i = 0; i < seq.size(); i++) begin
      memready = rdy[i];
      #1;
      n_cmp++;
      if (obs !== seq[i]) begin n_bad++; $display("FAIL lw cyc%0d got=%h exp=%h", i, obs, seq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw();
    ov_t seq[$];
    bit  rdy[$];
    op = 6'b101011;
    seq = '{V_F_WAIT, V_F_WAIT, V_F_RDY, V_DEC, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_MEMWR};
    rdy = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
    for (int i = 0; i < seq.size(); i++) begin
      memready = rdy[i];
      #1;
      n_cmp++;
      if (obs !== seq[i]) begin n_bad++; $display("FAIL sw cyc%0d got=%h exp=%h", i, obs, seq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    logic [5:0] ops[4] = '{6'b000100, 6'b000101, 6'b000101, 6'b000100};
    logic       zs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0};
    ov_t        brv[4] = '{V_BR_TK, V_BR_NT, V_BR_TK, V_BR_NT};
    ov_t        seq[3];
    for (int k = 0; k < 4; k++) begin
      op = ops[k]; zero = zs[k];
      seq = '{V_F_RDY, V_DEC, brv[k]};
      for (int i = 0; i < 3; i++) begin
        memready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== seq[i]) begin n_bad++; $display("FAIL branch%0d cyc%0d got=%h exp=%h", k, i, obs, seq[i]); end
        @(posedge clk); #1;
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_rtype();
    logic [5:0] fns[5]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] alus[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    ov_t        seq[4];
    ov_t        ex;
    op = 6'b000000;
    for (int k = 0; k < 5; k++) begin
      funct = fns[k];
      ex = V_REXEC;
      ex.alu = alus[k];
      seq = '{V_F_RDY, V_DEC, ex, V_RWB};
      for (int i = 0; i < 4; i++) begin
        memready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== seq[i]) begin n_bad++; $display("FAIL rtype%0d cyc%0d got=%h exp=%h", k, i, obs, seq[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_unsupported();
    logic [5:0] ops[2] = '{6'b000000, 6'b111111};
    ov_t        seq[2] = '{V_F_RDY, V_DEC};
    funct = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      op = ops[k];
      for (int i = 0; i < 2; i++) begin
        memready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== seq[i]) begin n_bad++; $display("FAIL unsup%0d cyc%0d got=%h exp=%h", k, i, obs, seq[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] ops[4]  = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [2:0] alus[4] = '{3'b010, 3'b000, 3'b001, 3'b111};
    logic       ies[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
    ov_t        seq[4];
    ov_t        ex;
    for (int k = 0; k < 4; k++) begin
      op = ops[k];
      ex = V_IEXEC;
      ex.alu = alus[k];
      ex.ie  = ies[k];
      seq = '{V_F_RDY, V_DEC, ex, V_IWB};
      for (int i = 0; i < 4; i++) begin
        memready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== seq[i]) begin n_bad++; $display("FAIL itype%0d cyc%0d got=%h exp=%h", k, i, obs, seq[i]); end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jump();
    ov_t seq[3] = '{V_F_RDY, V_DEC, V_JUMP};
    op = 6'b000010;
    for (int i = 0; i < 3; i++) begin
      memready = 1'b1;
      #1;
      n_cmp++;
      if (obs !== seq[i]) begin n_bad++; $display("FAIL jump cyc%0d got=%h exp=%h", i, obs, seq[i]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midwrite();
    ov_t seq[4] = '{V_F_RDY, V_DEC, V_MEMADR, V_MEMWR};
    bit  rdy[4] = '{1, 1, 1, 0};
    op = 6'b101011;
    for (int i = 0; i < 4; i++) begin
      memready = rdy[i];
      #1;
      n_cmp++;
      if (obs !== seq[i]) begin n_bad++; $display("FAIL rstwr cyc%0d got=%h exp=%h", i, obs, seq[i]); end
      if (i < 3) begin @(posedge clk); #1; end
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== V_WR_RST) begin n_bad++; $display("FAIL rstwr_force got=%h exp=%h", obs, V_WR_RST); end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (obs !== V_F_RST) begin n_bad++; $display("FAIL rstwr_hold%0d got=%h exp=%h", i, obs, V_F_RST); end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_F_WAIT) begin n_bad++; $display("FAIL rstwr_release got=%h exp=%h", obs, V_F_WAIT); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_branch();
    test_rtype();
    test_unsupported();
    test_itype();
    test_jump();
    test_reset_midwrite();
    memready = 1'b0;
    #1;
    n_cmp++;
    if (obs !== V_F_WAIT) begin n_bad++; $display("FAIL final_fetch got=%h exp=%h", obs, V_F_WAIT); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
